// File: rtl/ksa_core_arbiter.sv
// N-core coordinator for the RC4 key search: hands out equal key ranges, launches all cores together,
// latches the first reported key (lowest core index wins) and aborts the rest. Optional KSA_TIMEOUT_EN adds a search cycle limit.
module ksa_core_arbiter #(
  parameter int N_CORES        = 4,
  parameter int KEY_WIDTH      = 24,
  parameter int SEARCH_BITS    = 22,
  parameter int TIMEOUT_CYCLES = 2**26,
  localparam int WIN_W         = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  output logic [N_CORES-1:0]             core_start,
  output logic [N_CORES-1:0]             core_abort,
  output logic [N_CORES*KEY_WIDTH-1:0]   core_key_lo,
  output logic [N_CORES*KEY_WIDTH-1:0]   core_key_hi,
  input  logic [N_CORES-1:0]             core_found,
  input  logic [N_CORES-1:0]             core_not_found,
  input  logic [N_CORES*KEY_WIDTH-1:0]   core_key,
  output logic                           busy,
  output logic                           key_valid,
  output logic                           search_failed,
  output logic [WIN_W-1:0]               winner_idx,
  output logic [KEY_WIDTH-1:0]           display_key,
  output logic [2:0]                     state_dbg
);

  localparam longint SPAN = (longint'(1) << SEARCH_BITS) / N_CORES;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_SEARCH    = 3'd2,
    S_FOUND     = 3'd3,
    S_EXHAUSTED = 3'd4
`ifdef KSA_TIMEOUT_EN
    , S_TIMEOUT = 3'd5
`endif
  } state_t;

  state_t               state, state_next;
  logic [WIN_W-1:0]     winner_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic                 abort_q;
  logic                 found_any;
  logic [WIN_W-1:0]     found_idx;
  logic [KEY_WIDTH-1:0] found_key;

  if (N_CORES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
  end

`ifdef KSA_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] cycle_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  cycle_cnt <= '0;
    else if (state == S_LAUNCH) cycle_cnt <= '0;
    else if (state == S_SEARCH) cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

  // Ranges are constants, but registered so they read 0 while in reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      core_key_lo <= '0;
      core_key_hi <= '0;
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        core_key_lo[i*KEY_WIDTH +: KEY_WIDTH] <= KEY_WIDTH'(longint'(i) * SPAN);
        core_key_hi[i*KEY_WIDTH +: KEY_WIDTH] <= KEY_WIDTH'(longint'(i + 1) * SPAN - 1);
      end
    end
  end

  // Downward scan leaves the lowest set index as the winner.
  always_comb begin
    found_any = |core_found;
    found_idx = '0;
    found_key = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (core_found[i]) begin
        found_idx = WIN_W'(i);
        found_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_FOUND, S_EXHAUSTED: if (start) state_next = S_LAUNCH;
`ifdef KSA_TIMEOUT_EN
      S_TIMEOUT: if (start) state_next = S_LAUNCH;
`endif
      S_LAUNCH: state_next = S_SEARCH;
      S_SEARCH: begin
        if (found_any)            state_next = S_FOUND;
        else if (&core_not_found) state_next = S_EXHAUSTED;
`ifdef KSA_TIMEOUT_EN
        else if (cycle_cnt == TIMEOUT_LAST) state_next = S_TIMEOUT;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      winner_q <= '0;
      key_q    <= '0;
      abort_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == S_LAUNCH) begin
        winner_q <= '0;
        key_q    <= '0;
        abort_q  <= 1'b0;
      end else if (state == S_SEARCH && found_any) begin
        winner_q <= found_idx;
        key_q    <= found_key;
        abort_q  <= 1'b1;
      end
`ifdef KSA_TIMEOUT_EN
      else if (state == S_SEARCH && state_next == S_TIMEOUT) begin
        abort_q <= 1'b1;
      end
`endif
    end
  end

  always_comb begin
    core_start    = {N_CORES{state == S_LAUNCH}};
    core_abort    = {N_CORES{abort_q}};
    busy          = (state == S_LAUNCH) || (state == S_SEARCH);
    key_valid     = (state == S_FOUND);
`ifdef KSA_TIMEOUT_EN
    search_failed = (state == S_EXHAUSTED) || (state == S_TIMEOUT);
`else
    search_failed = (state == S_EXHAUSTED);
`endif
    winner_idx    = winner_q;
    display_key   = key_valid ? key_q : '0;
    state_dbg     = state;
  end

endmodule
